// File: rtl/e_muldiv_seq_pkg.sv
// e_muldiv_seq_pkg: op encodings and FSM states shared by the iterative mul/div unit.
package e_muldiv_seq_pkg;
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/e_muldiv_seq.sv
// e_muldiv_seq: one-bit-per-cycle shift-add multiply / restoring divide for the E stage.
// Define E_MULDIV_DIV0_FLAG_EN to add a registered div0 output flagging divide-by-zero.
module e_muldiv_seq
  import e_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef E_MULDIV_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic is_div, neg_a, neg_b, accept, last, sgn_op, sa, sb;
  logic [2*WIDTH-1:0] acc, mstep, dstep, res;
  logic [WIDTH-1:0] b, ma, mb, q, r, qf, rf;
  logic [WIDTH:0] sum, diff;
  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);
  assign accept = start && !req && ((state == IDLE) || (state == DONE));
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    sgn_op = (op == MD_MULT) || (op == MD_DIV);
    sa = sgn_op && rs[WIDTH-1];
    sb = sgn_op && rt[WIDTH-1];
    ma = sa ? -rs : rs;
    mb = sb ? -rt : rt;
    state_n = accept ? CALC : (state == CALC) ? (last ? FIX : CALC) : (state == FIX) ? DONE : IDLE;
  end
  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b};
    mstep = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b};
    dstep = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    q = acc[WIDTH-1:0];
    r = acc[2*WIDTH-1:WIDTH];
    qf = (b == '0) ? {WIDTH{1'b1}} : ((neg_a ^ neg_b) ? -q : q);
    rf = neg_a ? -r : r;
    res = is_div ? {rf, qf} : ((neg_a ^ neg_b) ? -acc : acc);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      acc <= '0;
      b <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= '0;
        is_div <= op[1];
        neg_a <= sa;
        neg_b <= sb;
        b <= op[1] ? mb : ma;
        acc <= {{WIDTH{1'b0}}, op[1] ? ma : mb};
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? dstep : mstep;
      end else if (state == FIX) begin
        {hi, lo} <= res;
      end
    end
  end
`ifdef E_MULDIV_DIV0_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div0 <= 1'b0;
    else div0 <= (state == FIX) && is_div && (b == '0);
  end
`endif
endmodule

// File: tb/tb_e_muldiv_seq.sv
// tb_e_muldiv_seq: directed scoreboard bench for e_muldiv_seq (WIDTH=32).
module tb_e_muldiv_seq;
  import e_muldiv_seq_pkg::*;
  logic clk = 0, reset = 1, start = 0, req = 0;
  logic [1:0] op = 0;
  logic [31:0] rs = 0, rt = 0;
  logic busy, done;
  logic [31:0] hi, lo;
`ifdef E_MULDIV_DIV0_FLAG_EN
  logic div0;
`endif
  int n_cmp = 0, n_err = 0;
  logic [64:0] sb_q[$];
  logic [63:0] last_res = 0;
  bit seen_done;

  always #5 clk = ~clk;

  e_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .req(req), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef E_MULDIV_DIV0_FLAG_EN
    , .div0(div0)
`endif
  );

  // bit 64 = expected div0 flag, bits 63:0 = expected {hi,lo}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    longint sa = $signed(a);
    longint sd = $signed(d);
    longint qq, mm;
    logic [63:0] res;
    if (o == MD_MULT) res = 64'(sa * sd);
    else if (o == MD_MULTU) res = {32'b0, a} * {32'b0, d};
    else if (d == 0) res = {a, 32'hFFFFFFFF};
    else if (o == MD_DIV) begin
      qq = sa / sd;
      mm = sa % sd;
      res = {mm[31:0], qq[31:0]};
    end else res = {a % d, a / d};
    return {o[1] && (d == 0), res};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    start = 1; req = 0; op = o; rs = a; rt = d;
    sb_q.push_back(model(o, a, d));
  endtask

  task automatic wait_result(input string tag, input int inj, input bit chain,
                             input logic [1:0] co, input logic [31:0] ca, input logic [31:0] cd);
    logic [64:0] e;
    bit got = 0;
    @(posedge clk);
    #1 start = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, "_busy_first"}, 64'(busy), 64'd1);
      if (k == 10) check({tag, "_hold_calc"}, {hi, lo}, last_res);
      if (k == 33) begin
        check({tag, "_busy_last"}, 64'(busy), 64'd1);
        check({tag, "_early_done"}, 64'(done), 64'd0);
      end
      if (done) begin
        got = 1;
        check({tag, "_latency"}, 64'(k), 64'd34);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        e = sb_q.pop_front();
        check({tag, "_result"}, {hi, lo}, e[63:0]);
        last_res = e[63:0];
`ifdef E_MULDIV_DIV0_FLAG_EN
        check({tag, "_div0"}, 64'(div0), 64'(e[64]));
`endif
        if (chain) drive(co, ca, cd);
      end
      if (k == inj) begin start = 1; op = MD_MULTU; rs = 2; rt = 3; end
      if (k == inj + 1) start = 0;
    end
    if (!got) begin
      check({tag, "_timeout"}, 64'(got), 64'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 0;
    @(negedge clk);
    drive(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_result("multu_max", 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(MD_MULT, 32'hFFFFFFFD, 32'd5);
    wait_result("mult_neg", 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_result("div_neg", 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_result("div_ovf", 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(MD_DIVU, 32'd7, 32'd0);
    wait_result("divu_zero", 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(MD_DIV, 32'hFFFFFFFB, 32'd0);
    wait_result("div_zero_neg", 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(MD_DIV, 32'd100, 32'hFFFFFFF9);
    wait_result("start_while_busy", 5, 0, 0, 0, 0);
    @(negedge clk);
    start = 1; req = 1; op = MD_MULTU; rs = 32'd9; rt = 32'd9;
    @(negedge clk);
    start = 0; req = 0;
    repeat (3) @(negedge clk);
    check("req_busy", 64'(busy), 64'd0);
    check("req_done", 64'(done), 64'd0);
    check("req_hilo", {hi, lo}, last_res);
    drive(MD_DIVU, 32'hFFFFFFFF, 32'd3);
    wait_result("chain_first", 0, 1, MD_MULT, 32'h12345678, 32'hFFFFFFFE);
    wait_result("chain_second", 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(MD_MULTU, 32'hDEADBEEF, 32'h1234);
    @(posedge clk);
    #1 start = 0;
    repeat (10) @(negedge clk);
    #2 reset = 1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    void'(sb_q.pop_front());
    last_res = 0;
    @(negedge clk);
    reset = 0;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check("rst_no_done", 64'(seen_done), 64'd0);
    check("rst_queue_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
